// File: rtl/memx_defs_pkg.sv
// ---------------------------------------------------------------------------
// memx_defs
//   Shared definitions for the x-vector memory (memX) and the blocks that
//   talk to it: default geometry of a memory row and the state encoding of
//   the row writer.
// ---------------------------------------------------------------------------
package memx_defs;

  localparam int ELEMENT_WIDTH = 64;
  localparam int NO_OF_UNITS   = 8;
  localparam int ADDRESS_WIDTH = 20;
  localparam int LANE_WIDTH    = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } writer_state_t;

endpackage

// File: rtl/memx_row_merge.sv
// ---------------------------------------------------------------------------
// memx_row_merge
//   Combinational lane merge for a partial memory row. Each lane whose mask
//   bit is set takes the freshly collected element; every other lane keeps
//   the value currently stored in memX.
//
//   Ports:
//     row_buf_i    collected elements, lane 0 in the low bits
//     lane_mask_i  one bit per lane, 1 = lane was written this row
//     read_data_i  current row content from memX's combinational read port
//     merged_o     row to be written back
// ---------------------------------------------------------------------------
module memx_row_merge
  import memx_defs::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_units   = NO_OF_UNITS
) (
  input  logic [no_of_units*element_width-1:0] row_buf_i,
  input  logic [no_of_units-1:0]               lane_mask_i,
  input  logic [no_of_units*element_width-1:0] read_data_i,
  output logic [no_of_units*element_width-1:0] merged_o
);

  for (genvar g = 0; g < no_of_units; g++) begin : g_lane
    assign merged_o[g*element_width +: element_width] =
      lane_mask_i[g] ? row_buf_i[g*element_width +: element_width]
                     : read_data_i[g*element_width +: element_width];
  end

endmodule

// File: rtl/memx_row_writer.sv
// ---------------------------------------------------------------------------
// memx_row_writer
//   Write-back stage in front of memX. Solver results arrive one element at
//   a time on a valid/ready stream, are packed no_of_units to a row and
//   written with one memX write per row. A final partial row is merged with
//   the existing row content so lanes that were not produced are preserved.
//
//   Ports:
//     clk, reset            clock; asynchronous active-high reset
//     start                 command strobe, only honoured in IDLE
//     base_address          first row to write
//     element_count         number of elements in the command
//     in_valid/in_data      element stream in
//     in_ready              element accepted this cycle when high with in_valid
//     mem_read_address      row currently being assembled (merge read)
//     mem_read_data         memX combinational read data
//     mem_write_enable      one-cycle memX write strobe
//     mem_write_address     row written this cycle
//     mem_write_data        merged row written this cycle
//     busy                  command in progress
//     done                  one-cycle completion pulse
// ---------------------------------------------------------------------------
module memx_row_writer
  import memx_defs::*;
#(
  parameter int element_width = ELEMENT_WIDTH,
  parameter int no_of_units   = NO_OF_UNITS,
  parameter int address_width = ADDRESS_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic [address_width-1:0]             element_count,
  input  logic                                 in_valid,
  input  logic [element_width-1:0]             in_data,
  output logic                                 in_ready,
  output logic [address_width-1:0]             mem_read_address,
  input  logic [no_of_units*element_width-1:0] mem_read_data,
  output logic                                 mem_write_enable,
  output logic [address_width-1:0]             mem_write_address,
  output logic [no_of_units*element_width-1:0] mem_write_data,
  output logic                                 busy,
  output logic                                 done
);

  localparam int lane_width = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam logic [lane_width-1:0]    LAST_LANE = lane_width'(no_of_units - 1);
  localparam logic [address_width-1:0] ONE_LEFT  = address_width'(1);

  writer_state_t                               state_q, state_d;
  logic [address_width-1:0]                    row_addr_q, row_addr_d;
  logic [address_width-1:0]                    remaining_q, remaining_d;
  logic [lane_width-1:0]                       lane_q, lane_d;
  logic [no_of_units-1:0]                      lane_mask_q, lane_mask_d;
  logic [no_of_units-1:0][element_width-1:0]   row_buf_q, row_buf_d;
  logic [no_of_units*element_width-1:0]        merged_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_addr_q  <= '0;
      remaining_q <= '0;
      lane_q      <= '0;
      lane_mask_q <= '0;
      row_buf_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_addr_q  <= row_addr_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      lane_mask_q <= lane_mask_d;
      row_buf_q   <= row_buf_d;
    end
  end

  // A row closes either when its last lane fills or when the command runs
  // out of elements; the WRITE cycle then decides whether more rows follow.
  always_comb begin
    state_d     = state_q;
    row_addr_d  = row_addr_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    lane_mask_d = lane_mask_q;
    row_buf_d   = row_buf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (element_count != '0) begin
            row_addr_d  = base_address;
            remaining_d = element_count;
            lane_d      = '0;
            lane_mask_d = '0;
            state_d     = COLLECT;
          end else begin
            state_d = DONE;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          row_buf_d[lane_q]   = in_data;
          lane_mask_d[lane_q] = 1'b1;
          lane_d              = lane_q + 1'b1;
          remaining_d         = remaining_q - 1'b1;
          if (lane_q == LAST_LANE || remaining_q == ONE_LEFT) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (remaining_q == '0) begin
          state_d = DONE;
        end else begin
          // Row address wraps naturally at 2^address_width.
          row_addr_d  = row_addr_q + 1'b1;
          lane_d      = '0;
          lane_mask_d = '0;
          state_d     = COLLECT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  memx_row_merge #(
    .element_width (element_width),
    .no_of_units   (no_of_units)
  ) u_merge (
    .row_buf_i   (row_buf_q),
    .lane_mask_i (lane_mask_q),
    .read_data_i (mem_read_data),
    .merged_o    (merged_row)
  );

  // Write port is held at zero outside WRITE so memX sees a quiet bus.
  assign in_ready          = (state_q == COLLECT);
  assign mem_write_enable  = (state_q == WRITE);
  assign mem_write_address = mem_write_enable ? row_addr_q : '0;
  assign mem_write_data    = mem_write_enable ? merged_row : '0;
  assign mem_read_address  = row_addr_q;
  assign busy              = (state_q == COLLECT) || (state_q == WRITE);
  assign done              = (state_q == DONE);

endmodule
